uart_nco_tickgen: RTL and testbench
===================================

// Module: uart_nco_tickgen
// PURPOSE
// - Multi-channel NCO baud-tick generator for the UART TX and RX paths.
// - Each channel is a phase accumulator. It produces a one-cycle tick on accumulator
//   carry-out and a ~50% duty dds_clk taken from the accumulator MSB.
// - Increments are reloaded at runtime through a valid/ready port. A new increment takes
//   effect only on a tick boundary, so a live baud change never gives a short or long bit.
// - Per-channel clear realigns phase to mid-period, for RX start-bit centring.
// PARAMETERS
// - PHASE_WIDTH  32            accumulator width in bits (>=4)
// - NUM_CH       2             number of independent channels (>=1)
// - DEFAULT_INC  32'h0000_C49C increment loaded into every channel at reset
// - CNT_WIDTH    16            tick counter width; used only with UART_NCO_TICK_CNT_EN
// PORTS
// - clk        in   1                  system clock
// - rst_n      in   1                  reset, asynchronous, active-low
// - en         in   NUM_CH             per-channel run enable
// - clr        in   NUM_CH             per-channel phase realign pulse
// - cfg_valid  in   1                  increment write request
// - cfg_ready  out  1                  write is accepted when cfg_valid & cfg_ready
// - cfg_ch     in   $clog2(NUM_CH)|1   target channel (width is 1 when NUM_CH=1)
// - cfg_inc    in   PHASE_WIDTH        new phase increment
// - cfg_err    out  1                  one-cycle pulse: accepted write had cfg_ch >= NUM_CH
// - tick       out  NUM_CH             one-cycle pulse per accumulator wrap
// - dds_clk    out  NUM_CH             registered accumulator MSB
// - tick_cnt   out  NUM_CH*CNT_WIDTH   free-running tick counters (UART_NCO_TICK_CNT_EN only)
// BEHAVIOUR
// - Reset:
//   - acc=0, inc=DEFAULT_INC, pending=0.
//   - tick=0, dds_clk=0, cfg_err=0, tick_cnt=0.
//   - Outputs are valid from the first edge after reset is released.
// - Per channel, each clk with en=1 and clr=0:
//   - sum = {1'b0,acc} + {1'b0,inc}, computed PHASE_WIDTH+1 bits wide.
//   - acc <= sum[PHASE_WIDTH-1:0]; tick <= sum[PHASE_WIDTH]; dds_clk <= acc[MSB] (old acc).
//   - Period in cycles = 2^PHASE_WIDTH / inc, with fractional jitter of at most 1 cycle.
//   - inc=0: acc holds and no tick is produced.
// - en=0: acc <= 0, tick <= 0, dds_clk <= 0. en=0 overrides clr.
// - clr=1 (with en=1):
//   - acc <= 2^(PHASE_WIDTH-1), tick <= 0, dds_clk <= 0.
//   - The next tick arrives half a period later.
// - Config handshake:
//   - cfg_ready = ~pending[cfg_ch]. cfg_ready is 1 for any out-of-range cfg_ch.
//   - An accepted in-range write stores cfg_inc in stage[ch] and sets pending[ch].
//   - An accepted out-of-range write is dropped, and cfg_err pulses on the next cycle.
// - Applying a pending increment (inc <= stage, pending <= 0):
//   - Enabled channel: applied on the same edge that registers tick=1. The wrapping add uses
//     the old inc; the following add uses the new inc.
//   - Disabled channel, or channel being cleared: applied on the next edge.
//   - A channel with inc=0 never ticks, so its pending increment is applied only after
//     en=0 or clr.
// - Simultaneous events: every channel is updated every cycle regardless of cfg traffic.
//   A second write to a channel stalls (cfg_ready=0) until its pending increment is applied.
// - Reset mid-operation: immediate asynchronous return to the reset values. Any staged
//   increment is discarded.
// CONFIGURATION
// - UART_NCO_TICK_CNT_EN defined:
//   - Each channel has a CNT_WIDTH counter that increments on tick and wraps modulo 2^CNT_WIDTH.
//   - The counter is cleared by reset and by en=0, and is not affected by clr.
// - Not defined: no counter logic, and tick_cnt is driven to all zeros.
// STRUCTURE
// - uart_nco_pkg holds:
//   - localparam NCO_PHASE_WIDTH_DEF=32;
//   - function calc_inc(clk_hz, baud_hz, os) returning round(baud*os*2^W/clk);
//   - typedef struct cfg_req_t {ch, inc}.
// - Sub-module uart_nco_channel: one accumulator, with its stage/pending logic and counter.
//   The top level instantiates it with a generate loop and decodes cfg_ch / cfg_ready.
// TESTING (bench runs PHASE_WIDTH=8, NUM_CH=2, DEFAULT_INC=64)
// - Free run, en=2'b11: tick every 4th cycle on both channels; dds_clk pattern 0,0,1,1
//   repeating.
// - Live reload: ch0 inc=64 -> write inc=32 mid-period. The in-flight 4-cycle period
//   completes, then period=8 cycles, with no tick gap shorter than 4.
// - Stall: two back-to-back ch1 writes. cfg_ready=0 for the second write until ch1's next
//   tick, then it is accepted.
// - clr: ch0 running inc=64, pulse clr -> the next tick comes 2 enabled cycles after clr,
//   with acc going 128 -> 192 -> wrap.
// - Error/disable: cfg_ch=1 with NUM_CH=1 -> cfg_err pulses once and inc is unchanged.
//   en=0 -> tick=0, dds_clk=0; a pending write is applied on the next cycle.
// - Async reset during a tick cycle: all outputs are 0 immediately. After release, the first
//   tick comes after 4 cycles; tick_cnt=0 when UART_NCO_TICK_CNT_EN is defined.

Source files
------------

// File: rtl/uart_nco_pkg.sv
// Shared defaults, increment helper and config request type for the UART NCO tick generator.
package uart_nco_pkg;

  localparam int NCO_PHASE_WIDTH_DEF = 32;

  typedef struct packed {
    logic [7:0]                     ch;
    logic [NCO_PHASE_WIDTH_DEF-1:0] inc;
  } cfg_req_t;

  // round(baud * os * 2^W / clk) for the default accumulator width
  function automatic longint unsigned calc_inc(longint unsigned clk_hz, longint unsigned baud_hz,
                                               longint unsigned os);
    longint unsigned num;
    num = (baud_hz * os) << NCO_PHASE_WIDTH_DEF;
    return (num + clk_hz / 2) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_nco_channel.sv
// One NCO channel: phase accumulator, staged increment reload and optional tick counter.
// Optional counter enabled by defining UART_NCO_TICK_CNT_EN.
module uart_nco_channel
  import uart_nco_pkg::*;
#(
  parameter int                     PHASE_WIDTH = NCO_PHASE_WIDTH_DEF,
  parameter logic [PHASE_WIDTH-1:0] DEFAULT_INC = '0,
  parameter int                     CNT_WIDTH   = 16
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   wr,
  input  logic [PHASE_WIDTH-1:0] wr_inc,
  output logic                   pending,
  output logic                   tick,
  output logic                   dds_clk,
  output logic [CNT_WIDTH-1:0]   tick_cnt
);

  localparam logic [PHASE_WIDTH-1:0] HALF = {1'b1, {(PHASE_WIDTH-1){1'b0}}};

  logic [PHASE_WIDTH-1:0] acc, inc, stage;
  logic [PHASE_WIDTH:0]   sum;
  logic                   run, wrap, apply;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign run   = en & ~clr;
  assign wrap  = run & sum[PHASE_WIDTH];
  // Reload only on a wrap so the bit in flight keeps its length
  assign apply = pending & (~run | wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      inc     <= DEFAULT_INC;
      stage   <= '0;
      pending <= 1'b0;
      tick    <= 1'b0;
      dds_clk <= 1'b0;
    end else begin
      if (!en) begin
        acc     <= '0;
        tick    <= 1'b0;
        dds_clk <= 1'b0;
      end else if (clr) begin
        acc     <= HALF;
        tick    <= 1'b0;
        dds_clk <= 1'b0;
      end else begin
        acc     <= sum[PHASE_WIDTH-1:0];
        tick    <= sum[PHASE_WIDTH];
        dds_clk <= acc[PHASE_WIDTH-1];
      end
      if (wr) begin
        stage   <= wr_inc;
        pending <= 1'b1;
      end else if (apply) begin
        inc     <= stage;
        pending <= 1'b0;
      end
    end
  end

`ifdef UART_NCO_TICK_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (!en)   cnt <= '0;
    else if (wrap)  cnt <= cnt + CNT_WIDTH'(1);
  end

  assign tick_cnt = cnt;
`else
  assign tick_cnt = '0;
`endif

endmodule

// File: rtl/uart_nco_tickgen.sv
// Multi-channel NCO baud-tick generator; decodes the config port onto per-channel NCOs.
// Optional per-channel tick counters enabled by defining UART_NCO_TICK_CNT_EN.
module uart_nco_tickgen
  import uart_nco_pkg::*;
#(
  parameter int                     PHASE_WIDTH = NCO_PHASE_WIDTH_DEF,
  parameter int                     NUM_CH      = 2,
  parameter logic [PHASE_WIDTH-1:0] DEFAULT_INC = PHASE_WIDTH'(32'h0000_C49C),
  parameter int                     CNT_WIDTH   = 16,
  localparam int                    CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             en,
  input  logic [NUM_CH-1:0]             clr,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [CH_W-1:0]               cfg_ch,
  input  logic [PHASE_WIDTH-1:0]        cfg_inc,
  output logic                          cfg_err,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             dds_clk,
  output logic [NUM_CH*CNT_WIDTH-1:0]   tick_cnt
);

  localparam int PAD = 2 ** CH_W;

  logic [NUM_CH-1:0] pending;
  logic [PAD-1:0]    pend_pad;
  logic              in_range, accept;

  // Padded copy keeps the pending lookup legal for any cfg_ch value
  assign pend_pad  = PAD'(pending);
  assign in_range  = (cfg_ch < CH_W'(NUM_CH)) || (PAD == NUM_CH);
  assign cfg_ready = ~in_range | ~pend_pad[cfg_ch];
  assign accept    = cfg_valid & cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= accept & ~in_range;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr;
    assign wr = accept & in_range & (cfg_ch == CH_W'(g));

    uart_nco_channel #(
      .PHASE_WIDTH (PHASE_WIDTH),
      .DEFAULT_INC (DEFAULT_INC),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en[g]),
      .clr      (clr[g]),
      .wr       (wr),
      .wr_inc   (cfg_inc),
      .pending  (pending[g]),
      .tick     (tick[g]),
      .dds_clk  (dds_clk[g]),
      .tick_cnt (tick_cnt[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_uart_nco_tickgen.sv
// Directed + random bench for uart_nco_tickgen (8-bit phase, 2 channels, inc 64) with a phase model.
module tb_uart_nco_tickgen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  en, clr;
  logic        cfg_valid;
  logic [0:0]  cfg_ch;
  logic [7:0]  cfg_inc;
  logic        cfg_ready, cfg_err;
  logic [1:0]  tick, dds_clk;
  logic [31:0] tick_cnt;

  logic        en1, clr1, cfg_valid1;
  logic [0:0]  cfg_ch1;
  logic [7:0]  cfg_inc1;
  logic        cfg_ready1, cfg_err1, tick1, dds1;
  logic [15:0] tick_cnt1;

  always #5 clk = ~clk;

  uart_nco_tickgen #(.PHASE_WIDTH(8), .NUM_CH(2), .DEFAULT_INC(8'd64), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_err(cfg_err), .tick(tick), .dds_clk(dds_clk),
    .tick_cnt(tick_cnt)
  );

  uart_nco_tickgen #(.PHASE_WIDTH(8), .NUM_CH(1), .DEFAULT_INC(8'd64), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .clr(clr1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
    .cfg_ch(cfg_ch1), .cfg_inc(cfg_inc1), .cfg_err(cfg_err1), .tick(tick1), .dds_clk(dds1),
    .tick_cnt(tick_cnt1)
  );

  int errors = 0;
  int checks = 0;

  // phase model: integer phase in [0,256), one entry per channel
  int m_acc[2], m_inc[2], m_stage[2], m_cnt[2];
  bit m_pend[2], m_tick[2], m_dds[2];
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_inc[i] = 64; m_stage[i] = 0; m_cnt[i] = 0;
      m_pend[i] = 0; m_tick[i] = 0; m_dds[i] = 0;
    end
    last_acc = 0;
  endtask

  // advance model and DUT by one edge, then compare every dut0 output
  task automatic cyc();
    bit take, run, wrap, apply;
    int s;
    logic [31:0] exp_cnt;
    take = cfg_valid && !m_pend[cfg_ch];
    for (int i = 0; i < 2; i++) begin
      run   = en[i] && !clr[i];
      s     = m_acc[i] + m_inc[i];
      wrap  = run && (s >= 256);
      apply = m_pend[i] && (!run || wrap);
      m_dds[i]  = run && (m_acc[i] >= 128);
      m_tick[i] = wrap;
      m_acc[i]  = !en[i] ? 0 : (clr[i] ? 128 : s % 256);
      m_cnt[i]  = !en[i] ? 0 : (wrap ? (m_cnt[i] + 1) % 65536 : m_cnt[i]);
      if (apply) begin m_inc[i] = m_stage[i]; m_pend[i] = 0; end
      if (take && cfg_ch == i) begin m_stage[i] = cfg_inc; m_pend[i] = 1; end
    end
    last_acc = take;
    @(posedge clk); #1;
    chk("tick", {30'b0, tick}, {30'b0, m_tick[1], m_tick[0]});
    chk("dds_clk", {30'b0, dds_clk}, {30'b0, m_dds[1], m_dds[0]});
    chk("cfg_ready", {31'b0, cfg_ready}, {31'b0, !m_pend[cfg_ch]});
    chk("cfg_err", {31'b0, cfg_err}, 32'd0);
`ifdef UART_NCO_TICK_CNT_EN
    exp_cnt = {16'(m_cnt[1]), 16'(m_cnt[0])};
`else
    exp_cnt = 32'd0;
`endif
    chk("tick_cnt", tick_cnt, exp_cnt);
  endtask

  task automatic wait_tick0(input string tag, input int max, output int n);
    n = 0;
    do begin cyc(); n++; end while (!tick[0] && n < max);
    if (!tick[0]) chk({tag, "_timeout"}, {31'b0, tick[0]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nt;
    logic [3:0] pat;
    bit saw;

    rst_n = 1'b0; en = 2'b00; clr = 2'b00; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_inc = 8'd0;
    en1 = 1'b0; clr1 = 1'b0; cfg_valid1 = 1'b0; cfg_ch1 = 1'b0; cfg_inc1 = 8'd0;
    model_reset();
    #22;
    chk("rst_tick", {30'b0, tick}, 32'd0);
    chk("rst_dds", {30'b0, dds_clk}, 32'd0);
    chk("rst_err", {31'b0, cfg_err}, 32'd0);
    chk("rst_cnt", tick_cnt, 32'd0);
    chk("rst_ready", {31'b0, cfg_ready}, 32'd1);
    chk("rst_dut1", {14'b0, tick1, dds1, tick_cnt1}, 32'd0);

    // free run: period 4, dds 0,0,1,1
    @(negedge clk); rst_n = 1'b1; en = 2'b11; en1 = 1'b1;
    nt = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (tick[0]) nt++;
      if (c < 4) pat[c] = dds_clk[0];
    end
    chk("free_ticks", nt, 3);
    chk("free_dds_pat", {28'b0, pat}, 32'hC);

    // live reload mid-period: in-flight period completes, then period 8
    cyc(); cyc();
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'd32;
    cyc();
    chk("reload_acc", {31'b0, last_acc}, 32'd1);
    cfg_valid = 1'b0;
    wait_tick0("reload1", 10, n); chk("reload_first_gap", n, 1);
    wait_tick0("reload2", 20, n); chk("reload_period", n, 8);
    wait_tick0("reload3", 20, n); chk("reload_period2", n, 8);

    // stall: second write to ch1 held off until ch1 wraps
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'd32;
    cyc();
    chk("stall_first_acc", {31'b0, last_acc}, 32'd1);
    cfg_inc = 8'd128;
    #1 chk("stall_ready_low", {31'b0, cfg_ready}, 32'd0);
    saw = 0; n = 0;
    do begin
      cyc(); n++;
      if (tick[1]) saw = 1;
    end while (!last_acc && n < 20);
    chk("stall_second_acc", {31'b0, last_acc}, 32'd1);
    chk("stall_after_tick", {31'b0, saw}, 32'd1);
    cfg_valid = 1'b0; cfg_ch = 1'b0;

    // clr: ch0 back to inc 64, then realign
    cfg_valid = 1'b1; cfg_inc = 8'd64;
    cyc();
    cfg_valid = 1'b0;
    wait_tick0("clr_apply", 20, n);
    cyc();
    clr = 2'b01;
    cyc();
    clr = 2'b00;
    wait_tick0("clr", 10, n); chk("clr_tick_dist", n, 2);

    // disable with a pending write: applied on the next edge
    cfg_valid = 1'b1; cfg_inc = 8'd16;
    cyc();
    cfg_valid = 1'b0; en = 2'b10;
    cyc();
    chk("dis_tick", {31'b0, tick[0]}, 32'd0);
    chk("dis_dds", {31'b0, dds_clk[0]}, 32'd0);
    chk("dis_ready", {31'b0, cfg_ready}, 32'd1);
    en = 2'b11;
    wait_tick0("dis_newinc", 30, n); chk("dis_newinc_period", n, 16);

    // out-of-range write on the single-channel instance
    cfg_valid1 = 1'b1; cfg_ch1 = 1'b1; cfg_inc1 = 8'd8;
    #1 chk("err_ready", {31'b0, cfg_ready1}, 32'd1);
    cyc();
    chk("err_pulse", {31'b0, cfg_err1}, 32'd1);
    cfg_valid1 = 1'b0;
    cyc();
    chk("err_once", {31'b0, cfg_err1}, 32'd0);
    n = 0;
    while (!tick1 && n < 20) begin cyc(); n++; end
    n = 0;
    do begin cyc(); n++; end while (!tick1 && n < 20);
    chk("err_inc_kept", n, 4);

    // async reset in a tick cycle
    wait_tick0("ares", 40, n);
    #2 rst_n = 1'b0;
    #1;
    chk("ares_tick", {30'b0, tick}, 32'd0);
    chk("ares_dds", {30'b0, dds_clk}, 32'd0);
    chk("ares_cnt", tick_cnt, 32'd0);
    chk("ares_err", {31'b0, cfg_err}, 32'd0);
    #2 rst_n = 1'b1;
    model_reset();
    wait_tick0("ares_first", 10, n); chk("ares_first_tick", n, 4);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      en[0]     = ($urandom_range(0, 9) != 0);
      en[1]     = ($urandom_range(0, 9) != 0);
      clr[0]    = ($urandom_range(0, 19) == 0);
      clr[1]    = ($urandom_range(0, 19) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 1'($urandom_range(0, 1));
      cfg_inc   = 8'($urandom_range(0, 255));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
